// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipeline control logic.
package rv32i_types;

  // Stall sequencer state: RUN while the pipeline advances, WAIT while frozen.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } pipe_ctrl_state_t;

  localparam int unsigned XLEN = 32;

endpackage

// File: rtl/pipeline_stall_ctrl_resp_hold.sv
// Sticky capture of one cache response that arrives while the pipeline is
// frozen, with a bypass mux so a same-cycle response passes straight through.
module resp_hold
  import rv32i_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            resp,
  input  logic [XLEN-1:0] rdata,
  input  logic            advance,
  output logic            done,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] hold;

  // Capture an early response; release it when the pipeline finally advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      hold <= '0;
    end else if (advance) begin
      done <= 1'b0;
    end else if (resp) begin
      done <= 1'b1;
      hold <= rdata;
    end
  end

  // Present held data once captured, otherwise the live cache data.
  always_comb begin
    data = done ? hold : rdata;
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline: gates cache
// requests, holds early responses, resolves load-use and mispredict hazards.
module pipeline_stall_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_resp_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        dmem_req_i,
  input  logic        dmem_resp_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        load_use_i,
  input  logic        br_mispredict_i,
  output logic        imem_read_o,
  output logic        dmem_gate_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] mem_rdata_o,
  output logic        pc_sel_o,
  output logic        load_pc_o,
  output logic        load_if_id_o,
  output logic        load_id_ex_o,
  output logic        load_ex_mem_o,
  output logic        load_mem_wb_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  pipe_ctrl_state_t state, next_state;

  logic i_done;
  logic d_done;
  logic i_ok;
  logic d_ok;
  logic advance;

  resp_hold u_i_hold (
    .clk     (clk),
    .rst     (rst),
    .resp    (imem_resp_i),
    .rdata   (imem_rdata_i),
    .advance (advance),
    .done    (i_done),
    .data    (if_instr_o)
  );

  resp_hold u_d_hold (
    .clk     (clk),
    .rst     (rst),
    .resp    (dmem_resp_i),
    .rdata   (dmem_rdata_i),
    .advance (advance),
    .done    (d_done),
    .data    (mem_rdata_o)
  );

  // The pipeline moves only when both the fetch and any data access are satisfied.
  always_comb begin
    i_ok        = imem_resp_i | i_done;
    d_ok        = ~dmem_req_i | dmem_resp_i | d_done;
    advance     = i_ok & d_ok;
    imem_read_o = ~rst & ~i_done;
    dmem_gate_o = ~rst & dmem_req_i & ~d_done;
  end

  // State register for the run/wait sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next state follows advance: any frozen cycle parks the sequencer in WAIT.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     next_state = advance ? RUN : WAIT;
      WAIT:    next_state = advance ? RUN : WAIT;
      default: next_state = RUN;
    endcase
  end

  // Stage-register control; mispredict beats load-use, and nothing moves while frozen.
  always_comb begin
    pc_sel_o      = 1'b0;
    load_pc_o     = 1'b0;
    load_if_id_o  = 1'b0;
    load_id_ex_o  = 1'b0;
    load_ex_mem_o = 1'b0;
    load_mem_wb_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    if (!rst && advance) begin
      load_id_ex_o  = 1'b1;
      load_ex_mem_o = 1'b1;
      load_mem_wb_o = 1'b1;
      if (br_mispredict_i) begin
        pc_sel_o      = 1'b1;
        load_pc_o     = 1'b1;
        load_if_id_o  = 1'b1;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (load_use_i) begin
        flush_id_ex_o = 1'b1;
      end else begin
        load_pc_o    = 1'b1;
        load_if_id_o = 1'b1;
      end
    end
  end

  // Performance counters: frozen cycles and mispredict flushes actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (!advance) begin
        stall_cycles_o <= stall_cycles_o + 32'd1;
      end
      if (advance && br_mispredict_i) begin
        flush_count_o <= flush_count_o + 32'd1;
      end
    end
  end

endmodule
